// File: rtl/riscv_run_controller.sv
// riscv_run_controller: sequences core reset, run, halt/timeout detection and write signature.
// Optional signature logic is enabled by defining RUN_CTRL_SIG_EN.
module riscv_run_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH = 32,
   parameter int RESET_CYCLES = 2,
   parameter int MAX_CYCLES = 1000,
   parameter int HALT_CYCLES = 4,
   parameter logic [DATA_WIDTH-1:0] EXPECTED_SIG = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic                  rf_we,
   input  logic [4:0]            rf_wa,
   input  logic [DATA_WIDTH-1:0] rf_wd,
   output logic                  core_rst_n,
   output logic                  running,
   output logic                  done,
   output logic                  halted,
   output logic                  timeout,
   output logic                  pass,
   output logic [CNT_WIDTH-1:0]  cycle_count,
   output logic [CNT_WIDTH-1:0]  retire_count,
   output logic [DATA_WIDTH-1:0] signature
);
   localparam int RW = $clog2(RESET_CYCLES + 1);
   localparam int SW = $clog2(HALT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
   state_t state, next_state;
   logic [RW-1:0] rst_cnt;
   logic [SW-1:0] stall_cnt;
   logic [DATA_WIDTH-1:0] prev_pc;
   logic same, halt_hit, to_hit, retire, enter;
   // the first RUN cycle has no valid prev_pc, so it never counts as a match
   assign same = (pc == prev_pc) && (cycle_count != '0);
   assign halt_hit = (state == RUN) && same && (stall_cnt == SW'(HALT_CYCLES - 1));
   assign to_hit = (state == RUN) && (cycle_count == CNT_WIDTH'(MAX_CYCLES - 1)) && !halt_hit;
   assign retire = (state == RUN) && rf_we && (rf_wa != 5'd0);
   assign enter = (state != RESET) && (next_state == RESET);
   assign running = (state == RUN);
   assign done = (state == DONE);
   always_comb begin
      next_state = state;
      case (state)
         IDLE:  next_state = start ? RESET : IDLE;
         RESET: next_state = (rst_cnt == RW'(RESET_CYCLES - 1)) ? RUN : RESET;
         RUN:   next_state = (halt_hit || to_hit) ? DONE : RUN;
         DONE:  next_state = start ? RESET : DONE;
         default: next_state = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         core_rst_n <= 1'b0;
         rst_cnt <= '0;
         stall_cnt <= '0;
         prev_pc <= '0;
         cycle_count <= '0;
         retire_count <= '0;
         halted <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state <= next_state;
         core_rst_n <= (next_state == RUN) || (next_state == DONE);
         rst_cnt <= (state == RESET) ? rst_cnt + RW'(1) : '0;
         if (enter) begin
            stall_cnt <= '0;
            cycle_count <= '0;
            retire_count <= '0;
            halted <= 1'b0;
            timeout <= 1'b0;
         end else if (state == RUN) begin
            cycle_count <= cycle_count + CNT_WIDTH'(1);
            prev_pc <= pc;
            stall_cnt <= same ? stall_cnt + SW'(1) : '0;
            if (halt_hit) halted <= 1'b1;
            if (to_hit) timeout <= 1'b1;
            if (retire) retire_count <= retire_count + CNT_WIDTH'(1);
         end
      end
   end
`ifdef RUN_CTRL_SIG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) signature <= '0;
      else if (enter) signature <= '0;
      else if (retire) signature <= {signature[DATA_WIDTH-2:0], signature[DATA_WIDTH-1]} ^ rf_wd ^ DATA_WIDTH'(rf_wa);
   end
   assign pass = halted && (signature == EXPECTED_SIG);
`else
   logic unused_wd;
   assign unused_wd = ^rf_wd;
   assign signature = '0;
   assign pass = halted;
`endif
endmodule

// File: tb/tb_riscv_run_controller.sv
// tb_riscv_run_controller: scoreboard bench for the run controller (MAX_CYCLES=20, EXPECTED_SIG=9).
module tb_riscv_run_controller;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, rf_we = 1'b0;
   logic [31:0] pc = '0, rf_wd = '0;
   logic [4:0] rf_wa = '0;
   logic core_rst_n, running, done, halted, timeout, pass;
   logic [31:0] cycle_count, retire_count, signature;
   int compared = 0, mismatched = 0;
`ifdef RUN_CTRL_SIG_EN
   localparam bit SIG = 1'b1;
`else
   localparam bit SIG = 1'b0;
`endif
   typedef struct {logic h, t, p; logic [31:0] cc, rc, sg;} exp_t;
   exp_t sb[$];
   logic [36:0] wq[$];

   riscv_run_controller #(.DATA_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(2), .MAX_CYCLES(20),
      .HALT_CYCLES(4), .EXPECTED_SIG(32'h9)) dut (
      .clk(clk), .rst(rst), .start(start), .pc(pc), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .core_rst_n(core_rst_n), .running(running), .done(done), .halted(halted), .timeout(timeout),
      .pass(pass), .cycle_count(cycle_count), .retire_count(retire_count), .signature(signature));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic h, input logic t, input logic [31:0] cc, input logic [31:0] rc, input logic [31:0] sg);
      exp_t e;
      e.h = h; e.t = t; e.cc = cc; e.rc = rc;
      e.sg = SIG ? sg : 32'h0;
      e.p = SIG ? (h && sg == 32'h9) : h;
      sb.push_back(e);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      compared++;
      if (core_rst_n !== 1'b0 || running !== 1'b0 || cycle_count !== 0 || retire_count !== 0 || halted !== 1'b0 || timeout !== 1'b0) begin
         mismatched++;
         $display("FAIL start_entry: rst_n=%b run=%b cc=%0d rc=%0d h=%b t=%b, required 0 0 0 0 0 0", core_rst_n, running, cycle_count, retire_count, halted, timeout);
      end
      tick();
      compared++;
      if (core_rst_n !== 1'b0 || running !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_hold: rst_n=%b run=%b, required 0 0", core_rst_n, running);
      end
      tick();
      compared++;
      if (core_rst_n !== 1'b1 || running !== 1'b1 || cycle_count !== 0) begin
         mismatched++;
         $display("FAIL run_entry: rst_n=%b run=%b cc=%0d, required 1 1 0", core_rst_n, running, cycle_count);
      end
   endtask

   task automatic run_pc(input int steps, input int budget, input bit chk_seq);
      exp_t e;
      for (int cyc = 0; cyc < budget && !done; cyc++) begin
         pc = 32'(4 * (cyc < steps ? cyc : steps - 1));
         if (wq.size() > 0) begin
            {rf_wa, rf_wd} = wq.pop_front();
            rf_we = 1'b1;
         end else rf_we = 1'b0;
         tick();
         if (chk_seq && cyc < 3) begin
            compared++;
            if (running !== 1'b1 || cycle_count !== 32'(cyc + 1)) begin
               mismatched++;
               $display("FAIL seq_count: run=%b cc=%0d, required 1 %0d", running, cycle_count, cyc + 1);
            end
         end
      end
      rf_we = 1'b0;
      compared++;
      if (done !== 1'b1) begin
         mismatched++;
         $display("FAIL done_wait: done=%b after %0d cycles, required 1", done, budget);
      end
      e = sb.pop_front();
      compared++;
      if (halted !== e.h || timeout !== e.t || pass !== e.p) begin
         mismatched++;
         $display("FAIL flags: h=%b t=%b p=%b, required %b %b %b", halted, timeout, pass, e.h, e.t, e.p);
      end
      compared++;
      if (cycle_count !== e.cc || retire_count !== e.rc) begin
         mismatched++;
         $display("FAIL counts: cc=%0d rc=%0d, required %0d %0d", cycle_count, retire_count, e.cc, e.rc);
      end
      compared++;
      if (signature !== e.sg) begin
         mismatched++;
         $display("FAIL signature: got %h, required %h", signature, e.sg);
      end
      compared++;
      if (core_rst_n !== 1'b1 || running !== 1'b0) begin
         mismatched++;
         $display("FAIL done_outputs: rst_n=%b run=%b, required 1 0", core_rst_n, running);
      end
   endtask

   task automatic test_reset();
      tick();
      compared++;
      if (core_rst_n !== 1'b0 || running !== 1'b0 || done !== 1'b0 || halted !== 1'b0 || timeout !== 1'b0 || pass !== 1'b0 ||
          cycle_count !== 0 || retire_count !== 0 || signature !== 0) begin
         mismatched++;
         $display("FAIL reset_state: rst_n=%b run=%b done=%b h=%b t=%b p=%b cc=%0d rc=%0d sig=%h, required all 0",
            core_rst_n, running, done, halted, timeout, pass, cycle_count, retire_count, signature);
      end
      rst = 1'b0;
      tick();
      compared++;
      if (core_rst_n !== 1'b0 || running !== 1'b0) begin
         mismatched++;
         $display("FAIL idle_hold: rst_n=%b run=%b, required 0 0", core_rst_n, running);
      end
   endtask

   task automatic test_halt();
      do_start();
      push_exp(1'b1, 1'b0, 32'd7, 32'd0, 32'h0);
      run_pc(3, 40, 1'b1);
   endtask

   task automatic test_timeout();
      do_start();
      push_exp(1'b0, 1'b1, 32'd20, 32'd0, 32'h0);
      run_pc(1000, 40, 1'b0);
   endtask

   task automatic test_frozen();
      for (int i = 0; i < 3; i++) begin
         pc = 32'(100 + 4 * i);
         {rf_we, rf_wa, rf_wd} = {1'b1, 5'd5, 32'h7};
         tick();
         compared++;
         if (done !== 1'b1 || core_rst_n !== 1'b1 || cycle_count !== 20 || retire_count !== 0 || timeout !== 1'b1 || signature !== 0) begin
            mismatched++;
            $display("FAIL frozen: done=%b rst_n=%b cc=%0d rc=%0d t=%b sig=%h, required 1 1 20 0 1 0",
               done, core_rst_n, cycle_count, retire_count, timeout, signature);
         end
      end
      rf_we = 1'b0;
   endtask

   task automatic test_sig_pass();
      do_start();
      wq.push_back({5'd1, 32'h5});
      wq.push_back({5'd0, 32'hFF});
      wq.push_back({5'd2, 32'h3});
      push_exp(1'b1, 1'b0, 32'd7, 32'd2, 32'h9);
      run_pc(3, 40, 1'b0);
   endtask

   task automatic test_sig_fail();
      do_start();
      wq.push_back({5'd3, 32'h10});
      push_exp(1'b1, 1'b0, 32'd7, 32'd1, 32'h13);
      run_pc(3, 40, 1'b0);
   endtask

   task automatic test_simultaneous();
      do_start();
      push_exp(1'b1, 1'b0, 32'd20, 32'd0, 32'h0);
      run_pc(16, 40, 1'b0);
   endtask

   task automatic test_midrun_reset();
      do_start();
      wq.push_back({5'd4, 32'hA5});
      for (int i = 0; i < 3; i++) begin
         pc = 32'(4 * i);
         if (wq.size() > 0) begin
            {rf_wa, rf_wd} = wq.pop_front();
            rf_we = 1'b1;
         end else rf_we = 1'b0;
         tick();
      end
      rf_we = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      compared++;
      if (core_rst_n !== 1'b0 || running !== 1'b0 || done !== 1'b0 || halted !== 1'b0 || timeout !== 1'b0 ||
          cycle_count !== 0 || retire_count !== 0 || signature !== 0) begin
         mismatched++;
         $display("FAIL async_reset: rst_n=%b run=%b done=%b h=%b t=%b cc=%0d rc=%0d sig=%h, required all 0",
            core_rst_n, running, done, halted, timeout, cycle_count, retire_count, signature);
      end
      tick();
      rst = 1'b0;
      tick();
      test_halt();
   endtask

   initial begin
      test_reset();
      test_halt();
      test_timeout();
      test_frozen();
      test_sig_pass();
      test_sig_fail();
      test_simultaneous();
      test_midrun_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
